// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Instruction-issue controller for the 4x512-bit register-bank processor.
// A host streams 13-bit instructions into a small FIFO. A three-state FSM
// (IDLE -> ISSUE -> WAIT) pops them one at a time. Each pop produces a
// single-cycle issue strobe. The next issue is held off until the opcode's
// fixed latency has elapsed.
//
// Instruction format: [12:11] opcode, [10:9] register select, [8:0] address.
//   opcode 00 store / 01 load -> MEM_LAT wait cycles
//   opcode 10 add             -> ADD_LAT wait cycles
//   opcode 11 multiply        -> MUL_LAT wait cycles
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   in_instr       instruction offered by the host
//   in_valid       host offers in_instr
//   in_ready       FIFO can accept (registered occupancy != DEPTH)
//   stall          blocks a new pop while high (sampled in IDLE only)
//   issue_instr    last issued instruction; holds until the next pop
//   issue_valid    one-cycle issue strobe to the processor
//   op_done        one-cycle pulse in the final wait cycle of an operation
//   busy           high while in ISSUE or WAIT
//   fifo_count     FIFO occupancy, 0..DEPTH
//   retired_count  completed operations, wraps at 16 bits
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 3,
  parameter int MEM_LAT = 2,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [12:0]      in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  output logic [12:0]      issue_instr,
  output logic             issue_valid,
  output logic             op_done,
  output logic             busy,
  output logic [CNT_W:0]   fifo_count,
  output logic [15:0]      retired_count
);

  // Wide enough for any sensible latency setting.
  localparam int LAT_W = 8;
  localparam logic [CNT_W:0] FULL_COUNT = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [12:0]      mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] rd_ptr_reg;
  logic [CNT_W:0]   count_reg;

  // ---------------------------------------------------------------------------
  // FSM state and registered outputs
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic [LAT_W-1:0] wait_reg;
  logic [12:0]      issue_instr_reg;
  logic             issue_valid_reg;
  logic             op_done_reg;
  logic             busy_reg;
  logic [15:0]      retired_reg;

  logic push;
  logic pop;
  logic [LAT_W-1:0] issue_lat;

  // in_ready comes only from the registered count. A pop in the same cycle
  // therefore never opens room for a push. This keeps pop off the ready path.
  assign in_ready = (count_reg != FULL_COUNT);
  assign push     = in_valid && in_ready;
  assign pop      = (state_reg == IDLE) && (count_reg != '0) && !stall;

  // Wait length of the instruction currently held for issue.
  always_comb begin
    issue_lat = LAT_W'(MEM_LAT);
    case (issue_instr_reg[12:11])
      2'b10:   issue_lat = LAT_W'(ADD_LAT);
      2'b11:   issue_lat = LAT_W'(MUL_LAT);
      default: issue_lat = LAT_W'(MEM_LAT);
    endcase
  end

  // Storage array: written without reset so it maps onto RAM. Stale entries
  // left after a reset are unreachable because the pointers and count clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_instr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (CNT_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (CNT_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM. The popped head is read straight into issue_instr_reg, and that
  // register doubles as the read-data register of the storage array.
  // op_done is registered, so it is set one cycle early, on the edge that
  // enters the final wait cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      wait_reg        <= '0;
      issue_instr_reg <= '0;
      issue_valid_reg <= 1'b0;
      op_done_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      retired_reg     <= '0;
    end else begin
      issue_valid_reg <= 1'b0;
      op_done_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            issue_instr_reg <= mem[rd_ptr_reg];
            issue_valid_reg <= 1'b1;
            busy_reg        <= 1'b1;
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          wait_reg  <= issue_lat;
          state_reg <= WAIT;
          // A one-cycle operation is already in its final wait cycle next.
          if (issue_lat == LAT_W'(1)) begin
            op_done_reg <= 1'b1;
          end
        end
        WAIT: begin
          wait_reg <= wait_reg - LAT_W'(1);
          if (wait_reg == LAT_W'(2)) begin
            op_done_reg <= 1'b1;
          end
          if (wait_reg == LAT_W'(1)) begin
            retired_reg <= retired_reg + 16'd1;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign issue_instr   = issue_instr_reg;
  assign issue_valid   = issue_valid_reg;
  assign op_done       = op_done_reg;
  assign busy          = busy_reg;
  assign fifo_count    = count_reg;
  assign retired_count = retired_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Self-checking bench for instr_sequencer.
//
// Every clock step is compared against a timeline reference model. The model
// keeps the FIFO as a queue. It tracks only the cycle numbers of the current
// issue and completion. From those it derives the expected strobes, busy
// level and counters with plain arithmetic.
//
// On top of the model checks there are:
//   - a table of hand-derived vectors (load, then mul/add back-to-back),
//   - hand-written corner sequences: fill under stall, full-FIFO refusal,
//     reset during WAIT, and retired_count wrap,
//   - a randomized soak.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic [12:0] issue_instr;
  logic        issue_valid;
  logic        op_done;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] retired_count;

  always #5 clk = ~clk;

  instr_sequencer #(
    .DEPTH(8), .CNT_W(3), .MEM_LAT(2), .ADD_LAT(1), .MUL_LAT(4)
  ) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .stall(stall), .issue_instr(issue_instr),
    .issue_valid(issue_valid), .op_done(op_done), .busy(busy),
    .fifo_count(fifo_count), .retired_count(retired_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  logic [12:0] q[$];
  int          issue_cyc = -10;
  int          done_cyc  = -10;
  logic [15:0] m_retired = '0;
  logic [12:0] m_instr   = '0;

  // Log of issues observed on the DUT.
  logic [12:0] log_instr[$];
  int          log_time[$];

  function automatic int lat(logic [12:0] i);
    case (i[12:11])
      2'b10:   return 1;
      2'b11:   return 4;
      default: return 2;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    int          cnt_before;
    bit          do_pop;
    bit          do_push;
    logic [12:0] head;
    @(posedge clk);
    if (rst) begin
      q.delete();
      issue_cyc = -10;
      done_cyc  = -10;
      m_retired = '0;
      m_instr   = '0;
    end else begin
      if (cyc == done_cyc) m_retired = m_retired + 16'd1;
      cnt_before = q.size();
      do_pop  = (cyc > done_cyc) && (cnt_before > 0) && !stall;
      do_push = in_valid && (cnt_before < DEPTH);
      if (do_pop) begin
        head      = q.pop_front();
        m_instr   = head;
        issue_cyc = cyc + 1;
        done_cyc  = cyc + 1 + lat(head);
      end
      if (do_push) q.push_back(in_instr);
    end
    cyc++;
    #1;
    if (issue_valid === 1'b1) begin
      log_instr.push_back(issue_instr);
      log_time.push_back(cyc);
    end
    check("model.issue_valid", 32'(issue_valid), 32'(cyc == issue_cyc));
    check("model.op_done", 32'(op_done), 32'(cyc == done_cyc));
    check("model.busy", 32'(busy), 32'(cyc >= issue_cyc && cyc <= done_cyc));
    check("model.fifo_count", 32'(fifo_count), 32'(q.size()));
    check("model.in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("model.issue_instr", 32'(issue_instr), 32'(m_instr));
    check("model.retired_count", 32'(retired_count), 32'(m_retired));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    stall    = 1'b0;
    rst      = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (q.size() == 0 && cyc > done_cyc) return;
      step();
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [12:0] instr;
    logic        e_iv;
    logic        e_od;
    logic        e_busy;
    logic [12:0] e_ii;
    int          e_cnt;
    logic [15:0] e_ret;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic r, logic v, logic [12:0] ins, logic iv, logic od,
                              logic b, logic [12:0] ii, int cnt, logic [15:0] ret);
    vec_t t;
    t.rst = r; t.vld = v; t.instr = ins; t.e_iv = iv; t.e_od = od;
    t.e_busy = b; t.e_ii = ii; t.e_cnt = cnt; t.e_ret = ret;
    return t;
  endfunction

  logic [12:0] items[9];
  int          od_seen;

  initial begin
    // Inputs applied during a cycle; expected outputs after the edge.
    vecs[0]  = mk(1, 0, 13'h0000, 0, 0, 0, 13'h0000, 0, 0);
    vecs[1]  = mk(0, 1, 13'h0805, 0, 0, 0, 13'h0000, 1, 0);
    vecs[2]  = mk(0, 0, 13'h0000, 1, 0, 1, 13'h0805, 0, 0);
    vecs[3]  = mk(0, 0, 13'h0000, 0, 0, 1, 13'h0805, 0, 0);
    vecs[4]  = mk(0, 0, 13'h0000, 0, 1, 1, 13'h0805, 0, 0);
    vecs[5]  = mk(0, 0, 13'h0000, 0, 0, 0, 13'h0805, 0, 1);
    vecs[6]  = mk(0, 0, 13'h0000, 0, 0, 0, 13'h0805, 0, 1);
    vecs[7]  = mk(0, 1, 13'h1800, 0, 0, 0, 13'h0805, 1, 1);
    vecs[8]  = mk(0, 1, 13'h1000, 1, 0, 1, 13'h1800, 1, 1);
    vecs[9]  = mk(0, 0, 13'h0000, 0, 0, 1, 13'h1800, 1, 1);
    vecs[10] = mk(0, 0, 13'h0000, 0, 0, 1, 13'h1800, 1, 1);
    vecs[11] = mk(0, 0, 13'h0000, 0, 0, 1, 13'h1800, 1, 1);
    vecs[12] = mk(0, 0, 13'h0000, 0, 1, 1, 13'h1800, 1, 1);
    vecs[13] = mk(0, 0, 13'h0000, 0, 0, 0, 13'h1800, 1, 2);
    vecs[14] = mk(0, 0, 13'h0000, 1, 0, 1, 13'h1000, 0, 2);
    vecs[15] = mk(0, 0, 13'h0000, 0, 1, 1, 13'h1000, 0, 2);
    vecs[16] = mk(0, 0, 13'h0000, 0, 0, 0, 13'h1000, 0, 3);

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; stall = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; in_valid = vecs[i].vld; in_instr = vecs[i].instr; stall = 1'b0;
      step();
      check($sformatf("vec%0d.issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
      check($sformatf("vec%0d.op_done", i), 32'(op_done), 32'(vecs[i].e_od));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d.issue_instr", i), 32'(issue_instr), 32'(vecs[i].e_ii));
      check($sformatf("vec%0d.fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d.retired", i), 32'(retired_count), 32'(vecs[i].e_ret));
      $display("vec %0d: iv=%0b od=%0b busy=%0b ii=0x%0h cnt=%0d ret=%0d",
               i, issue_valid, op_done, busy, issue_instr, fifo_count, retired_count);
    end
    rst = 1'b0;

    // ---- fill under stall: 9 pushes, 8 kept; drain in order, spacing L+2 ----
    drain();
    stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      items[i] = 13'($urandom);
      items[i][12:11] = 2'(i % 4);
      in_valid = 1'b1; in_instr = items[i];
      step();
    end
    in_valid = 1'b0;
    check("fill.count", 32'(fifo_count), 32'd8);
    check("fill.ready", 32'(in_ready), 32'd0);
    stall = 1'b0;
    log_instr.delete(); log_time.delete();
    for (int k = 0; k < 100 && log_instr.size() < 8; k++) step();
    check("fill.issues", 32'(log_instr.size()), 32'd8);
    for (int i = 0; i < log_instr.size() && i < 8; i++) begin
      check($sformatf("fill.order%0d", i), 32'(log_instr[i]), 32'(items[i]));
      if (i > 0)
        check($sformatf("fill.spacing%0d", i), 32'(log_time[i] - log_time[i-1]),
              32'(lat(items[i-1]) + 2));
    end
    drain();
    check("fill.end_count", 32'(fifo_count), 32'd0);
    check("fill.end_ready", 32'(in_ready), 32'd1);
    $display("fill sequence: %0d issues seen", log_instr.size());

    // ---- full FIFO: push refused on the pop cycle, accepted on the next ----
    stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      items[i] = 13'($urandom);
      in_valid = 1'b1; in_instr = items[i];
      step();
    end
    check("full.count", 32'(fifo_count), 32'd8);
    stall = 1'b0; in_valid = 1'b1; in_instr = 13'h0ABC;
    log_instr.delete(); log_time.delete();
    step();
    check("full.refuse_count", 32'(fifo_count), 32'd7);
    check("full.refuse_ready", 32'(in_ready), 32'd1);
    step();
    check("full.accept_count", 32'(fifo_count), 32'd8);
    in_valid = 1'b0;
    drain();
    check("full.issues", 32'(log_instr.size()), 32'd9);
    if (log_instr.size() == 9) begin
      check("full.first", 32'(log_instr[0]), 32'(items[0]));
      check("full.last", 32'(log_instr[8]), 32'h0ABC);
    end
    $display("full sequence: %0d issues seen", log_instr.size());

    // ---- reset in the 2nd WAIT cycle of a multiply with 3 queued ----
    stall = 1'b1;
    in_valid = 1'b1; in_instr = 13'h1ABC; step();
    for (int i = 0; i < 3; i++) begin
      in_instr = 13'h1000 | 13'(i); step();
    end
    in_valid = 1'b0; stall = 1'b0;
    step();  // pop
    step();  // ISSUE
    step();  // WAIT 1
    step();  // WAIT 2
    check("rstmid.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid.count", 32'(fifo_count), 32'd0);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.op_done", 32'(op_done), 32'd0);
    check("rstmid.retired", 32'(retired_count), 32'd0);
    check("rstmid.issue_instr", 32'(issue_instr), 32'd0);
    check("rstmid.ready", 32'(in_ready), 32'd1);
    od_seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (op_done === 1'b1) od_seen++;
    end
    check("rstmid.no_op_done", 32'(od_seen), 32'd0);
    $display("reset-mid-op sequence: op_done pulses after reset=%0d", od_seen);

    // ---- retired_count wrap 0xFFFF -> 0x0000 ----
    drain();
    force dut.retired_reg = 16'hFFFF;
    m_retired = 16'hFFFF;
    step();
    release dut.retired_reg;
    in_valid = 1'b1; in_instr = 13'h1005;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("wrap.retired", 32'(retired_count), 32'd0);
    $display("wrap sequence: retired_count=0x%0h", retired_count);

    // ---- randomized soak against the model ----
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 399) == 0);
      in_valid = ($urandom_range(0, 99) < 55);
      stall    = ($urandom_range(0, 99) < 20);
      in_instr = 13'($urandom);
      step();
    end
    drain();
    $display("random soak: retired_count=%0d", retired_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
